// File: rtl/mul8_share_arb_if.sv
// mul8_share_arb_if: requester, multiplier and response signals of the
// shared 8x8 multiplier arbiter. The slave modport is the arbiter side and
// the master modport is the environment side (requesters, external
// multiplier and response consumer).
interface mul8_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_o;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_p;
    logic [15:0]       op_count;

    modport slave (
        input  req_valid, req_a, req_b, mul_o, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, op_count
    );

    modport master (
        output req_valid, req_a, req_b, mul_o, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, op_count
    );
endinterface

// File: rtl/mul8_share_arb.sv
// mul8_share_arb: round-robin arbiter feeding one external combinational
// 8x8 multiplier through a short valid/ready pipeline. S1 holds the granted
// operands (driving mul_a/mul_b), S2 captures mul_o and the requester ID.
// Optional build macro MUL8_SHARE_OUTREG_EN adds an S3 output register
// between S2 and the response bus (3-cycle latency instead of 2).
// Reset is synchronous and active-low; it drops every in-flight operation.
module mul8_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul8_share_arb_if.slave       bus
);

    // Pipeline state
    logic            r_s1_valid;
    logic [7:0]      r_s1_a;
    logic [7:0]      r_s1_b;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s2_valid;
    logic [15:0]     r_s2_p;
    logic [IDW-1:0]  r_s2_id;
`ifdef MUL8_SHARE_OUTREG_EN
    logic            r_s3_valid;
    logic [15:0]     r_s3_p;
    logic [IDW-1:0]  r_s3_id;
    logic            w_stall3;
`endif
    logic [IDW-1:0]  r_rr_ptr;
    logic [15:0]     r_op_count;

    // Combinational control
    logic            w_stall2;
    logic            w_s1_adv;
    logic            w_found;
    logic [IDW-1:0]  w_grant_idx;
    logic [IDW-1:0]  w_next_ptr;
    logic [7:0]      w_sel_a;
    logic [7:0]      w_sel_b;
    logic            w_accept;
    logic [NREQ-1:0] w_req_ready;
    logic            w_out_valid;
    logic            w_rsp_hs;

`ifdef MUL8_SHARE_OUTREG_EN
    // Output stage drives the bus; S2 only moves when S3 can take its data
    assign w_stall3    = r_s3_valid & ~bus.rsp_ready;
    assign w_stall2    = r_s2_valid & w_stall3;
    assign w_out_valid = r_s3_valid;
    assign bus.rsp_p   = r_s3_p;
    assign bus.rsp_id  = r_s3_id;
`else
    // S2 drives the response bus directly
    assign w_stall2    = r_s2_valid & ~bus.rsp_ready;
    assign w_out_valid = r_s2_valid;
    assign bus.rsp_p   = r_s2_p;
    assign bus.rsp_id  = r_s2_id;
`endif

    assign w_s1_adv      = ~r_s1_valid | ~w_stall2;
    assign w_rsp_hs      = w_out_valid & bus.rsp_ready;
    assign bus.rsp_valid = w_out_valid;
    assign bus.mul_a     = r_s1_a;
    assign bus.mul_b     = r_s1_b;
    assign bus.op_count  = r_op_count;
    assign bus.req_ready = w_req_ready;

    // Round-robin search from r_rr_ptr upward, wrapping at NREQ-1
    always_comb begin
        int v_idx;
        int v_grant;
        int v_next;
        v_idx       = 0;
        v_grant     = 0;
        v_next      = 0;
        w_found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end else begin
                v_idx = v_idx;
            end
            if (!w_found && bus.req_valid[v_idx]) begin
                w_found = 1'b1;
                v_grant = v_idx;
            end else begin
                w_found = w_found;
            end
        end
        v_next = v_grant + 1;
        if (v_next >= NREQ) begin
            v_next = 0;
        end else begin
            v_next = v_next;
        end
        w_grant_idx = IDW'(v_grant);
        w_next_ptr  = IDW'(v_next);
        w_sel_a     = bus.req_a[8*v_grant +: 8];
        w_sel_b     = bus.req_b[8*v_grant +: 8];
        // No grant while in reset or while S1 cannot move
        w_accept    = rst_n & w_s1_adv & w_found;
        if (w_accept) begin
            w_req_ready = NREQ'(1'b1) << w_grant_idx;
        end else begin
            w_req_ready = '0;
        end
    end

    // Arbiter pointer, operand stage, result stage and handshake counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_a     <= 8'd0;
            r_s1_b     <= 8'd0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_p     <= 16'd0;
            r_s2_id    <= '0;
            r_op_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= w_next_ptr;
            end
            // S1 takes the accept indication; operands only load on accept
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_a  <= w_sel_a;
                    r_s1_b  <= w_sel_b;
                    r_s1_id <= w_grant_idx;
                end
            end
            // S2 samples the external product while S1 holds its operands
            if (!w_stall2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_p  <= bus.mul_o;
                    r_s2_id <= r_s1_id;
                end
            end
            // Saturating count of completed responses
            if (w_rsp_hs && (r_op_count != 16'hFFFF)) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

`ifdef MUL8_SHARE_OUTREG_EN
    // Output register stage holding the response until it is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_p     <= 16'd0;
            r_s3_id    <= '0;
        end else if (!w_stall3) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_p  <= r_s2_p;
                r_s3_id <= r_s2_id;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul8_share_arb.sv
// tb_mul8_share_arb: directed phases with random operands, checked against a
// transaction-level model: a round-robin pointer, an in-order queue of
// outstanding operations stamped with the cycle they may reach the response
// bus, and a saturating handshake count.
module tb_mul8_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef MUL8_SHARE_OUTREG_EN
    localparam int D = 3;
`else
    localparam int D = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul8_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul8_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stand-in external multiplier: non-commutative so operand swaps show up
    function automatic logic [15:0] mulx(input logic [7:0] a, input logic [7:0] b);
        return (16'(a) * 16'(b)) + 16'(a);
    endfunction

    assign bus.mul_o = mulx(bus.mul_a, bus.mul_b);

    typedef struct {
        int          id;
        logic [15:0] p;
        int          vis;
    } ent_t;

    ent_t mq[$];
    int   m_ptr   = 0;
    int   m_cnt   = 0;
    int   ecount  = 0;
    bit   m_known = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model
    task automatic cyc(input logic [3:0] v, input logic rr, input logic rn,
                       input bit fixed, input logic [7:0] fa, input logic [7:0] fb);
        logic [31:0] a_bus;
        logic [31:0] b_bus;
        logic [3:0]  exp_rdy;
        int          g;
        bit          head_vis;
        for (int i = 0; i < NREQ; i++) begin
            a_bus[8*i +: 8] = fixed ? fa : 8'($urandom);
            b_bus[8*i +: 8] = fixed ? fb : 8'($urandom);
        end
        bus.req_valid = v;
        bus.req_a     = a_bus;
        bus.req_b     = b_bus;
        bus.rsp_ready = rr;
        rst_n         = rn;
        @(negedge clk);
        exp_rdy = 4'b0000;
        g = -1;
        if (rn && ((mq.size() < D) || rr)) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (g < 0 && v[i]) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        head_vis = (mq.size() > 0) && (mq[0].vis <= ecount);
        chk("req_ready", 16'(bus.req_ready), 16'(exp_rdy));
        if (m_known) begin
            chk("rsp_valid", 16'(bus.rsp_valid), 16'(head_vis));
            if (head_vis) begin
                chk("rsp_id", 16'(bus.rsp_id), 16'(mq[0].id));
                chk("rsp_p", bus.rsp_p, mq[0].p);
            end
            chk("op_count", bus.op_count, 16'(m_cnt));
        end
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            m_ptr   = 0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (head_vis && rr) begin
                void'(mq.pop_front());
                if (m_cnt < 65535) m_cnt++;
                if (mq.size() > 0 && mq[0].vis < ecount + 1) mq[0].vis = ecount + 1;
            end
            if (g >= 0) begin
                ent_t e;
                e.id  = g;
                e.p   = mulx(a_bus[8*g +: 8], b_bus[8*g +: 8]);
                e.vis = ecount + D;
                mq.push_back(e);
                m_ptr = (g + 1) % NREQ;
            end
        end
        ecount++;
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset with every requester asking: no grant while in reset
        repeat (2) cyc(4'b1111, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_mul_a", 16'(bus.mul_a), 16'h0000);
        chk("rst_mul_b", 16'(bus.mul_b), 16'h0000);
        chk("rst_rsp_p", bus.rsp_p, 16'h0000);
        chk("rst_rsp_id", 16'(bus.rsp_id), 16'h0000);
        chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0000);
        chk("rst_op_count", bus.op_count, 16'h0000);

        // Release: first grant to requester 0, then rotating order
        repeat (6) cyc(4'b1111, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

        // Requester 1 alone with a=0x00, b=0xAB
        cyc(4'b0010, 1'b1, 1'b1, 1'b1, 8'h00, 8'hAB);
        repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

        // All requesters continuously valid, consumer always ready
        repeat (12) cyc(4'b1111, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

        // Requester 2 stream with 5 cycles of backpressure
        repeat (3) cyc(4'b0100, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (5) cyc(4'b0100, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (6) cyc(4'b0100, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

        // Fill the pipeline, then reset: nothing in flight may come out
        repeat (4) cyc(4'b1111, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("midrst_rsp_valid", 16'(bus.rsp_valid), 16'h0000);
        chk("midrst_op_count", bus.op_count, 16'h0000);
        repeat (5) cyc(4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

        // Random traffic and random backpressure
        for (int n = 0; n < 400; n++) begin
            cyc(4'($urandom), ($urandom_range(0, 3) != 0), 1'b1, 1'b0, 8'h00, 8'h00);
        end
        repeat (6) cyc(4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);

        // Preload the counter near the top, then push it past saturation
        force dut.r_op_count = 16'hFFFD;
        m_cnt = 65533;
        #1;
        release dut.r_op_count;
        repeat (10) cyc(4'b1111, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        chk("sat_op_count", bus.op_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul8_share_arb.md
Name: mul8_share_arb

Overview:
- Round-robin arbiter and 2-stage pipeline sequencer that shares one combinational 8x8 approximate multiplier (any mul8_* instance) among NREQ requesters.
- The multiplier sits outside the block: the block drives its operands on mul_a/mul_b and samples its product on mul_o, so any mul8_* variant plugs in unchanged.
- Returns each product on a single response bus tagged with the requester ID, with valid/ready backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  operand B; same packing as req_a.
- mul_a  out  8  operand A to the external multiplier.
- mul_b  out  8  operand B to the external multiplier.
- mul_o  in  16  product from the external multiplier (combinational from mul_a/mul_b).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  requester index of the response.
- rsp_p  out  16  product.
- op_count  out  16  number of completed responses, saturating at 0xFFFF.

Behaviour:
- Reset (rst_n=0 at a clock edge): s1_valid=0, s2_valid=0, rr_ptr=0, op_count=0, rsp_valid=0, rsp_id=0, rsp_p=0, mul_a=0, mul_b=0. req_ready=0 while rst_n=0.
- Reset mid-operation discards all in-flight operations. No response is produced for them.
- Pipeline:
  - S1 holds the operand registers, s1_a, s1_b and s1_id; mul_a=s1_a, mul_b=s1_b.
  - S2 holds the result register, which drives rsp_p and rsp_id.
- Stall rules:
  - stall2 = s2_valid & ~rsp_ready.
  - s1_adv = ~s1_valid | ~stall2.
- Arbitration (combinational):
  - When s1_adv=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping NREQ-1 -> 0.
  - req_ready[i]=1 only for the granted i.
  - If no request is valid, req_ready=0.
  - A request is accepted when req_valid[i] & req_ready[i].
  - After an accept, rr_ptr = (granted i + 1) mod NREQ. Otherwise rr_ptr holds.
- S1 update when s1_adv=1: s1_valid takes the accept indication; on accept, the operands and ID are loaded. S1 holds when s1_adv=0.
- S2 update when ~stall2:
  - s2_valid takes s1_valid.
  - If s1_valid=1, rsp_p takes mul_o and rsp_id takes s1_id.
- Latency: accept in cycle N -> rsp_valid=1 in cycle N+2, with no stall.
- Throughput: one operation per cycle while rsp_ready=1.
- Simultaneous accept at S1 and drain at S2 in the same cycle is legal; no bubble is inserted.
- Backpressure: when rsp_ready=0 with both stages full, req_ready=0 and all registers hold. rsp_p, rsp_id and rsp_valid stay stable until the response is accepted.
- A requester that deasserts req_valid before being accepted loses nothing and is never granted.
- op_count increments by 1 on each rsp_valid & rsp_ready. It saturates at 0xFFFF and never wraps to 0.
- Product width: the full 16 bits of mul_o are passed through unmodified. No rounding or truncation.

Optional Feature:
- Macro MUL8_SHARE_OUTREG_EN.
- Defined:
  - Adds register stage S3 between S2 and the response bus, with the same stall rule: stall3 = s3_valid & ~rsp_ready, and S2 advances when ~s2_valid | ~stall3.
  - Latency becomes 3 cycles. Throughput stays one per cycle. Reset clears s3_valid.
- Undefined: 2-cycle latency exactly as above.
- op_count counts rsp handshakes in both builds.

Test Plan:
- Reset with all req_valid=1, then release rst_n -> req_ready=0 during reset; first grant goes to requester 0; rsp_valid first rises 2 cycles after accept, with rsp_id=0.
- Requester 1 only, a=0x00, b=0xAB -> rsp_p equals the external model's mul_o for (0x00,0xAB); rsp_id=1; latency 2 cycles (3 with MUL8_SHARE_OUTREG_EN).
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; one response per cycle; rsp_id sequence matches grant order.
- Stream from requester 2, then rsp_ready=0 for 5 cycles -> rsp_p/rsp_id held stable; req_ready=0 once S1 and S2 are full; no response lost or duplicated after rsp_ready returns to 1.
- rst_n=0 with both stages full -> next cycle rsp_valid=0 and op_count=0; no stale response appears after reset release.
- Preload 65535 handshakes (force or long run) plus 2 more -> op_count=0xFFFF, not 0x0000 or 0x0001.
